dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 47 ++++
 rtl/dmem_array.sv | 37 +++
 rtl/dmem_ctrl.sv | 129 ++++++++++++
 tb/tb_dmem_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller: access sizes, FSM states,
// byte-lane mask generation and load-data extension.
package dmem_pkg;

    typedef enum logic [1:0] {
        SizeByte = 2'd0,
        SizeHalf = 2'd1,
        SizeWord = 2'd2,
        SizeBad  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    // Helpers work on a fixed wide container; callers truncate to their own width.
    localparam int unsigned MAX_LANES = 64;
    localparam int unsigned MAX_W     = 8 * MAX_LANES;

    function automatic logic [MAX_LANES-1:0] lane_mask(input size_e       size,
                                                       input int unsigned off,
                                                       input int unsigned nbytes);
        logic [MAX_LANES-1:0] mask;
        case (size)
            SizeByte: mask = MAX_LANES'(1) << off;
            SizeHalf: mask = MAX_LANES'(3) << off;
            SizeWord: mask = {MAX_LANES{1'b1}} >> (MAX_LANES - nbytes);
            default:  mask = '0;
        endcase
        return mask;
    endfunction

    function automatic logic [MAX_W-1:0] extend_data(input logic [MAX_W-1:0] raw,
                                                     input size_e            size,
                                                     input logic             sgn);
        logic [MAX_W-1:0] res;
        case (size)
            SizeByte: res = {{(MAX_W - 8){sgn & raw[7]}}, raw[7:0]};
            SizeHalf: res = {{(MAX_W - 16){sgn & raw[15]}}, raw[15:0]};
            default:  res = raw;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous byte-enable write, combinational read.
// Contents power up as word i = i and are never touched by reset.
module dmem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [DATA_W/8-1:0]        be,
    input  logic [$clog2(DEPTH)-1:0]   idx,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata
);
    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] words [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [DATA_W-1:0] word_q = DATA_W'(i);

        always_ff @(posedge clk) begin
            if (we && idx == IDX_W'(i)) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (be[b]) begin
                        word_q[8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
        end

        assign words[i] = word_q;
    end

    assign rdata = words[idx];

endmodule

// File: rtl/dmem_ctrl.sv
// Single-outstanding data-memory controller: captures one request, waits WAIT_CYCLES,
// then answers in a one-cycle RESP state where stores commit and loads are returned.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);
    localparam int unsigned BYTES     = DATA_W / 8;
    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam int unsigned SHIFT     = $clog2(BYTES);
    localparam logic [2:0]  WAIT_INIT = 3'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              accept;

    logic              write_q, signed_q;
    size_e             size_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_INIT != 3'd0) begin
                        state_d = StWait;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= SizeByte;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (accept) begin
            write_q  <= req_write;
            signed_q <= req_signed;
            size_q   <= size_e'(req_size);
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
        end
    end

    // Decode of the captured request; all checks use registered fields only.
    int unsigned       off;
    logic [31:0]       word_addr;
    logic              out_of_range, misaligned, err;
    logic [IDX_W-1:0]  idx;
    logic [BYTES-1:0]  be;
    logic              we;
    logic [DATA_W-1:0] rd_word, load_data;

    always_comb begin
        off          = 32'(addr_q & 32'(BYTES - 1));
        word_addr    = addr_q >> SHIFT;
        out_of_range = word_addr >= 32'(DEPTH);
        misaligned   = ((size_q == SizeHalf) && (addr_q[0] || BYTES < 2)) ||
                       ((size_q == SizeWord) && (off != 0));
        err          = out_of_range || misaligned || (size_q == SizeBad);
        idx          = word_addr[IDX_W-1:0];
        be           = BYTES'(lane_mask(size_q, off, BYTES));
        we           = (state_q == StResp) && write_q && !err;
        load_data    = DATA_W'(extend_data(MAX_W'(rd_word >> (8 * off)), size_q, signed_q));
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .be    (be),
        .idx   (idx),
        .wdata (wdata_q << (8 * off)),
        .rdata (rd_word)
    );

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_err   = resp_valid && err;
    assign resp_rdata = (resp_valid && !err && !write_q) ? load_data : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: vector table on a WAIT_CYCLES=1 instance plus
// hand sequences for held request fields and reset during WAIT on a WAIT_CYCLES=3 instance.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        valid_a, valid_b;
    logic        req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic        a_ready, a_resp_valid, a_err;
    logic [31:0] a_rdata;
    logic        b_ready, b_resp_valid, b_err;
    logic [31:0] b_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.DATA_W(32), .DEPTH(256), .WAIT_CYCLES(1)) u_dut_a (
        .clk        (clk),
        .reset      (rst_a),
        .req_valid  (valid_a),
        .req_ready  (a_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (a_resp_valid),
        .resp_rdata (a_rdata),
        .resp_err   (a_err)
    );

    dmem_ctrl #(.DATA_W(32), .DEPTH(256), .WAIT_CYCLES(3)) u_dut_b (
        .clk        (clk),
        .reset      (rst_b),
        .req_valid  (valid_b),
        .req_ready  (b_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (b_resp_valid),
        .resp_rdata (b_rdata),
        .resp_err   (b_err)
    );

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 with the selected DUT idle; returns one cycle after its RESP.
    task automatic run_req(input bit use_b, input vec_t v, input int exp_lat, input string tag);
        int lat;
        bit seen;
        req_write  = v.write;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        check({tag, " ready"}, 32'(use_b ? b_ready : a_ready), 32'd1);
        if (use_b) valid_b = 1'b1; else valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        valid_b = 1'b0;
        check({tag, " busy"}, 32'(use_b ? b_ready : a_ready), 32'd0);
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 12) begin
            if (use_b ? b_resp_valid : a_resp_valid) seen = 1'b1;
            else begin
                step();
                lat++;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rdata"}, use_b ? b_rdata : a_rdata, v.exp_rdata);
        check({tag, " err"}, 32'(use_b ? b_err : a_err), 32'(v.exp_err));
        step();
        check({tag, " pulse"}, 32'(use_b ? b_resp_valid : a_resp_valid), 32'd0);
    endtask

    initial begin
        vec_t v;
        int   seen_resp;

        //              wr    size   sgn   addr        wdata          rdata          err
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        32'h000000DE, 1'b0};
        vecs[4]  = '{1'b1, 2'd1, 1'b0, 32'h12,  32'h00001234, 32'h00000000, 1'b0};
        vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h1234BEEF, 1'b0};
        vecs[6]  = '{1'b1, 2'd2, 1'b0, 32'h11,  32'hA5A5A5A5, 32'h00000000, 1'b1};
        vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h1234BEEF, 1'b0};
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h400, 32'h0,        32'h00000000, 1'b1};
        vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h8,   32'h0,        32'h00000002, 1'b0};
        vecs[10] = '{1'b0, 2'd3, 1'b0, 32'h0,   32'h0,        32'h00000000, 1'b1};
        vecs[11] = '{1'b0, 2'd1, 1'b1, 32'h10,  32'h0,        32'hFFFFBEEF, 1'b0};
        vecs[12] = '{1'b1, 2'd1, 1'b0, 32'h11,  32'h0000FFFF, 32'h00000000, 1'b1};
        vecs[13] = '{1'b1, 2'd0, 1'b0, 32'h21,  32'h777777AB, 32'h00000000, 1'b0};
        vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h20,  32'h0,        32'h0000AB08, 1'b0};
        vecs[15] = '{1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0,        32'h000000FF, 1'b0};

        rst_a      = 1'b0;
        rst_b      = 1'b0;
        valid_a    = 1'b0;
        valid_b    = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;

        #3;
        check("reset ready", 32'(a_ready), 32'd1);
        check("reset resp_valid", 32'(a_resp_valid), 32'd0);
        check("reset rdata", a_rdata, 32'd0);
        check("reset err", 32'(a_err), 32'd0);

        step();
        rst_a = 1'b1;
        rst_b = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_req(1'b0, vecs[i], 2, $sformatf("vec%0d", i));
        end

        // Fields changed and req_valid held during WAIT must not disturb the access.
        req_write  = 1'b0;
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_addr   = 32'h8;
        req_wdata  = 32'h0;
        valid_a    = 1'b1;
        step();
        req_write = 1'b1;
        req_wdata = 32'h55;
        req_addr  = 32'h8;
        check("held busy ready", 32'(a_ready), 32'd0);
        step();
        check("held resp_valid", 32'(a_resp_valid), 32'd1);
        check("held rdata", a_rdata, 32'h00000002);
        valid_a = 1'b0;
        step();
        v = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'h00000002, 1'b0};
        run_req(1'b0, v, 2, "held recheck");

        // Reset one cycle into WAIT on the WAIT_CYCLES=3 instance.
        req_write  = 1'b1;
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_addr   = 32'h40;
        req_wdata  = 32'hCAFEF00D;
        valid_b    = 1'b1;
        step();
        valid_b = 1'b0;
        check("abort busy", 32'(b_ready), 32'd0);
        step();
        rst_b = 1'b0;
        #1;
        check("abort ready", 32'(b_ready), 32'd1);
        check("abort resp_valid", 32'(b_resp_valid), 32'd0);
        check("abort rdata", b_rdata, 32'd0);
        seen_resp = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (b_resp_valid) seen_resp++;
        end
        rst_b = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (b_resp_valid) seen_resp++;
        end
        check("abort no response", 32'(seen_resp), 32'd0);
        v = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h00000010, 1'b0};
        run_req(1'b1, v, 4, "abort mem");
        v = '{1'b1, 2'd0, 1'b0, 32'h42, 32'h000000C3, 32'h00000000, 1'b0};
        run_req(1'b1, v, 4, "b store");
        v = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h00C30010, 1'b0};
        run_req(1'b1, v, 4, "b load");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
